bus_cycle_controller: RTL and testbench



---
 rtl/mackerel_bus_pkg.sv | 69 ++++++
 rtl/bus_watchdog.sv | 47 ++++
 rtl/bus_cycle_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_bus_cycle_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mackerel_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mackerel_bus_pkg
// Brief    : Shared types, address map and decode helper for the mackerel-30
//            bus cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package mackerel_bus_pkg;

  // Target of the current bus cycle
  typedef enum logic [2:0] {
    REGION_DRAM = 3'd0,
    REGION_ROM  = 3'd1,
    REGION_IO   = 3'd2,
    REGION_AVEC = 3'd3,
    REGION_NONE = 3'd4
  } region_e;

  // Bus cycle sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_FAULT  = 3'd4,
    ST_TERM   = 3'd5
  } bus_state_e;

  // Address map: a region matches when (addr & mask) == base
  localparam logic [31:0] c_dram_base = 32'h0000_0000;
  localparam logic [31:0] c_dram_mask = 32'hF800_0000;
  localparam logic [31:0] c_rom_base  = 32'hE000_0000;
  localparam logic [31:0] c_rom_mask  = 32'hFFF0_0000;
  localparam logic [31:0] c_io_base   = 32'hF000_0000;
  localparam logic [31:0] c_io_mask   = 32'hFFF0_0000;
  localparam logic [31:0] c_boot_base = 32'h0000_0000;
  localparam logic [31:0] c_boot_mask = 32'hFFF0_0000;

  // CPU space function code and the interrupt-acknowledge type field
  localparam logic [2:0] c_fc_cpu_space = 3'b111;
  localparam logic [3:0] c_iack_type    = 4'hF;

  // CPU space is checked first so an IACK is never mistaken for a boot fetch;
  // the boot window shadows the bottom of DRAM while the overlay is active.
  function automatic region_e decode_region(
    input logic [31:0] addr,
    input logic [2:0]  fc,
    input logic        boot_active
  );
    region_e region;
    region = REGION_NONE;
    if (fc == c_fc_cpu_space) begin
      if (addr[19:16] == c_iack_type) begin
        region = REGION_AVEC;
      end
    end else if (boot_active && ((addr & c_boot_mask) == c_boot_base)) begin
      region = REGION_ROM;
    end else if ((addr & c_dram_mask) == c_dram_base) begin
      region = REGION_DRAM;
    end else if ((addr & c_rom_mask) == c_rom_base) begin
      region = REGION_ROM;
    end else if ((addr & c_io_mask) == c_io_base) begin
      region = REGION_IO;
    end
    return region;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : bus_watchdog
// Brief    : Saturating bus-cycle timeout counter. 'expired' flags the cycle in
//            which the count reaches TIMEOUT_CYCLES (and stays set after).
// Revision : 1.0 - initial release
// ============================================================================
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise count up and stick at the limit
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != c_limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Flag on the next count so the consumer acts on the edge the limit is hit
  assign expired = (count_d == c_limit);

  // Count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : bus_cycle_controller
// Brief    : MC68030 bus cycle decoder for mackerel-30: chip selects, DSACK /
//            AVEC / BERR termination and the post-reset ROM boot overlay.
// Revision : 1.0 - initial release
// ============================================================================
module bus_cycle_controller
  import mackerel_bus_pkg::*;
#(
  parameter int ROM_WAIT       = 4,
  parameter int IO_WAIT        = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BOOT_CYCLES    = 8
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [31:0] ADDR,
  input  logic [2:0]  FC,
  input  logic        RW,
  input  logic        AS_n,
  input  logic        DSACK0_DRAM_n,
  input  logic        DSACK1_DRAM_n,
  output logic        CS_DRAM_n,
  output logic        CS_ROM_n,
  output logic        CS_IO_n,
  output logic        DSACK0_n,
  output logic        DSACK1_n,
  output logic        BERR_n,
  output logic        AVEC_n
);

  localparam int WAIT_MAX = (ROM_WAIT > IO_WAIT) ? ROM_WAIT : IO_WAIT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [WAIT_W-1:0] c_wait_max  = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] c_rom_cnt   = WAIT_W'(ROM_WAIT);
  localparam logic [WAIT_W-1:0] c_io_cnt    = WAIT_W'(IO_WAIT);
  localparam logic [WAIT_W-1:0] c_avec_cnt  = WAIT_W'(1);
  localparam logic [3:0]        c_boot_lim  = 4'(BOOT_CYCLES);

  // Registers
  logic        as_meta_q, as_meta_d;
  logic        as_s_q, as_s_d;
  bus_state_e  state_q, state_d;
  region_e     region_q, region_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic        cs_dram_n_q, cs_dram_n_d;
  logic        cs_rom_n_q, cs_rom_n_d;
  logic        cs_io_n_q, cs_io_n_d;
  logic        ack0_n_q, ack0_n_d;
  logic        ack1_n_q, ack1_n_d;
  logic        avec_n_q, avec_n_d;
  logic        berr_n_q, berr_n_d;

  // Combinational helpers
  region_e     w_region;
  logic        w_boot_active;
  logic        w_dram_ack;
  logic        w_wd_clear;
  logic        w_wd_enable;
  logic        w_wd_expired;
  logic        w_unused;

  // Direction does not affect selection or termination
  assign w_unused = RW;

  assign w_boot_active = (boot_cnt_q < c_boot_lim);
  assign w_region      = decode_region(ADDR, FC, w_boot_active);
  assign w_dram_ack    = (region_q == REGION_DRAM) && (!DSACK0_DRAM_n || !DSACK1_DRAM_n);
  assign w_wd_clear    = (state_q == ST_DECODE);
  assign w_wd_enable   = (state_q == ST_WAIT);

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (CLK),
    .rst_n   (RST_n),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  // Two-flop synchronizer for the asynchronous address strobe
  always_comb begin
    as_meta_d = AS_n;
    as_s_d    = as_meta_q;
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      as_meta_q   <= 1'b1;
      as_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      region_q    <= REGION_NONE;
      wait_cnt_q  <= '0;
      boot_cnt_q  <= '0;
      cs_dram_n_q <= 1'b1;
      cs_rom_n_q  <= 1'b1;
      cs_io_n_q   <= 1'b1;
      ack0_n_q    <= 1'b1;
      ack1_n_q    <= 1'b1;
      avec_n_q    <= 1'b1;
      berr_n_q    <= 1'b1;
    end else begin
      as_meta_q   <= as_meta_d;
      as_s_q      <= as_s_d;
      state_q     <= state_d;
      region_q    <= region_d;
      wait_cnt_q  <= wait_cnt_d;
      boot_cnt_q  <= boot_cnt_d;
      cs_dram_n_q <= cs_dram_n_d;
      cs_rom_n_q  <= cs_rom_n_d;
      cs_io_n_q   <= cs_io_n_d;
      ack0_n_q    <= ack0_n_d;
      ack1_n_q    <= ack1_n_d;
      avec_n_q    <= avec_n_d;
      berr_n_q    <= berr_n_d;
    end
  end

  // Next state, region latch, wait counter and boot counter
  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    wait_cnt_d = wait_cnt_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!as_s_q) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        region_d   = w_region;
        wait_cnt_d = '0;
        state_d    = (w_region == REGION_NONE) ? ST_FAULT : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q != c_wait_max) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        // A strobe release before any acknowledge is an abort, not an error
        if (as_s_q) begin
          state_d = ST_TERM;
        end else begin
          case (region_q)
            REGION_ROM:  if (wait_cnt_q == c_rom_cnt)  state_d = ST_ACK;
            REGION_IO:   if (wait_cnt_q == c_io_cnt)   state_d = ST_ACK;
            REGION_AVEC: if (wait_cnt_q == c_avec_cnt) state_d = ST_ACK;
            default:     state_d = ST_WAIT;
          endcase
          // A DRAM acknowledge landing with the timeout still terminates cleanly
          if ((state_d == ST_WAIT) && w_wd_expired && !w_dram_ack) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_ACK, ST_FAULT: begin
        if (as_s_q) begin
          state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        state_d = ST_IDLE;
        if (boot_cnt_q != c_boot_lim) begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output registers: set on state transitions, held otherwise, cleared leaving TERM
  always_comb begin
    cs_dram_n_d = cs_dram_n_q;
    cs_rom_n_d  = cs_rom_n_q;
    cs_io_n_d   = cs_io_n_q;
    ack0_n_d    = ack0_n_q;
    ack1_n_d    = ack1_n_q;
    avec_n_d    = avec_n_q;
    berr_n_d    = berr_n_q;
    if (state_q == ST_TERM) begin
      cs_dram_n_d = 1'b1;
      cs_rom_n_d  = 1'b1;
      cs_io_n_d   = 1'b1;
      ack0_n_d    = 1'b1;
      ack1_n_d    = 1'b1;
      avec_n_d    = 1'b1;
      berr_n_d    = 1'b1;
    end else if (state_q == ST_DECODE) begin
      cs_dram_n_d = (region_d != REGION_DRAM);
      cs_rom_n_d  = (region_d != REGION_ROM);
      cs_io_n_d   = (region_d != REGION_IO);
      berr_n_d    = (state_d != ST_FAULT);
    end else if (state_q == ST_WAIT) begin
      if (state_d == ST_ACK) begin
        ack0_n_d = (region_q != REGION_IO);
        ack1_n_d = (region_q != REGION_ROM);
        avec_n_d = (region_q != REGION_AVEC);
      end
      if (state_d == ST_FAULT) begin
        berr_n_d = 1'b0;
      end
    end
  end

  // DRAM acknowledges pass straight through while DRAM is selected
  assign DSACK0_n  = ack0_n_q & (DSACK0_DRAM_n | cs_dram_n_q);
  assign DSACK1_n  = ack1_n_q & (DSACK1_DRAM_n | cs_dram_n_q);
  assign CS_DRAM_n = cs_dram_n_q;
  assign CS_ROM_n  = cs_rom_n_q;
  assign CS_IO_n   = cs_io_n_q;
  assign BERR_n    = berr_n_q;
  assign AVEC_n    = avec_n_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_cycle_controller
// Brief    : Directed self-checking bench for bus_cycle_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_controller;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [31:0] ADDR;
  logic [2:0]  FC;
  logic        RW;
  logic        AS_n;
  logic        DSACK0_DRAM_n;
  logic        DSACK1_DRAM_n;
  logic        CS_DRAM_n, CS_ROM_n, CS_IO_n;
  logic        DSACK0_n, DSACK1_n, BERR_n, AVEC_n;

  // Output vector: {CS_DRAM_n, CS_ROM_n, CS_IO_n, DSACK0_n, DSACK1_n, BERR_n, AVEC_n}
  logic [6:0] obs;
  assign obs = {CS_DRAM_n, CS_ROM_n, CS_IO_n, DSACK0_n, DSACK1_n, BERR_n, AVEC_n};

  localparam logic [6:0] O_IDLE      = 7'b111_1111;
  localparam logic [6:0] O_ROM_CS    = 7'b101_1111;
  localparam logic [6:0] O_ROM_ACK   = 7'b101_1011;
  localparam logic [6:0] O_IO_CS     = 7'b110_1111;
  localparam logic [6:0] O_IO_ACK    = 7'b110_0111;
  localparam logic [6:0] O_DRAM_CS   = 7'b011_1111;
  localparam logic [6:0] O_DRAM_ACK  = 7'b011_0011;
  localparam logic [6:0] O_DRAM_BERR = 7'b011_1101;
  localparam logic [6:0] O_BERR      = 7'b111_1101;
  localparam logic [6:0] O_AVEC      = 7'b111_1110;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  bus_cycle_controller #(
    .ROM_WAIT       (4),
    .IO_WAIT        (8),
    .TIMEOUT_CYCLES (1024),
    .BOOT_CYCLES    (8)
  ) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .ADDR          (ADDR),
    .FC            (FC),
    .RW            (RW),
    .AS_n          (AS_n),
    .DSACK0_DRAM_n (DSACK0_DRAM_n),
    .DSACK1_DRAM_n (DSACK1_DRAM_n),
    .CS_DRAM_n     (CS_DRAM_n),
    .CS_ROM_n      (CS_ROM_n),
    .CS_IO_n       (CS_IO_n),
    .DSACK0_n      (DSACK0_n),
    .DSACK1_n      (DSACK1_n),
    .BERR_n        (BERR_n),
    .AVEC_n        (AVEC_n)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges and settle just after the last one
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [6:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed=%b expected=<none>", obs);
    end else begin
      x = sb_q.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s: observed=%b expected=%b", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic start_cycle(input logic [31:0] a, input logic [2:0] f);
    ADDR = a;
    FC   = f;
    RW   = 1'b1;
    AS_n = 1'b0;
  endtask

  // Boot-window ROM cycle run to completion without checks
  task automatic quick_rom_cycle();
    start_cycle(32'h0000_0000, 3'b110);
    step(12);
    AS_n = 1'b1;
    step(5);
  endtask

  // Hard stop in case the run never reaches its end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    RST_n = 1'b0; ADDR = '0; FC = 3'b000; RW = 1'b1; AS_n = 1'b1;
    DSACK0_DRAM_n = 1'b1; DSACK1_DRAM_n = 1'b1;

    // Reset state
    expect_out("reset_outputs", O_IDLE);
    step(3); check_out();
    RST_n = 1'b1;
    step(1);

    // First boot cycle: address 0 maps to ROM
    expect_out("boot0_pre_cs", O_IDLE);
    expect_out("boot0_cs_rom", O_ROM_CS);
    expect_out("boot0_no_ack_yet", O_ROM_CS);
    expect_out("boot0_dsack1", O_ROM_ACK);
    expect_out("boot0_release_hold", O_ROM_ACK);
    expect_out("boot0_release", O_IDLE);
    start_cycle(32'h0000_0000, 3'b110);
    step(3); check_out();
    step(1); check_out();
    step(4); check_out();
    step(1); check_out();
    AS_n = 1'b1;
    step(3); check_out();
    step(1); check_out();
    step(1);

    // Boot cycles 2..7
    for (int i = 0; i < 6; i++) quick_rom_cycle();

    // Eighth cycle still inside the overlay
    expect_out("boot7_still_rom", O_ROM_CS);
    expect_out("boot7_dsack1", O_ROM_ACK);
    expect_out("boot7_release", O_IDLE);
    start_cycle(32'h0000_0000, 3'b110);
    step(4); check_out();
    step(5); check_out();
    AS_n = 1'b1;
    step(4); check_out();
    step(1);

    // Overlay gone: address 0 is DRAM, acks pass through in the same cycle
    expect_out("post_boot_pre_cs", O_IDLE);
    expect_out("post_boot_cs_dram", O_DRAM_CS);
    expect_out("post_boot_passthru", O_DRAM_ACK);
    expect_out("post_boot_release", O_IDLE);
    start_cycle(32'h0000_0000, 3'b110);
    step(3); check_out();
    step(1); check_out();
    step(2);
    DSACK0_DRAM_n = 1'b0; DSACK1_DRAM_n = 1'b0;
    #1; check_out();
    AS_n = 1'b1;
    step(4); check_out();
    DSACK0_DRAM_n = 1'b1; DSACK1_DRAM_n = 1'b1;
    step(1);

    // DRAM read at 0x1000
    expect_out("dram_cs", O_DRAM_CS);
    expect_out("dram_waiting", O_DRAM_CS);
    expect_out("dram_passthru", O_DRAM_ACK);
    expect_out("dram_release_hold", O_DRAM_ACK);
    expect_out("dram_release_gated", O_IDLE);
    start_cycle(32'h0000_1000, 3'b101);
    step(4); check_out();
    step(3); check_out();
    DSACK0_DRAM_n = 1'b0; DSACK1_DRAM_n = 1'b0;
    #1; check_out();
    AS_n = 1'b1;
    step(3); check_out();
    step(1); check_out();
    DSACK0_DRAM_n = 1'b1; DSACK1_DRAM_n = 1'b1;
    step(1);

    // I/O read: DSACK0 only, IO_WAIT+1 edges after CS
    expect_out("io_cs", O_IO_CS);
    expect_out("io_no_ack_yet", O_IO_CS);
    expect_out("io_dsack0", O_IO_ACK);
    expect_out("io_release_hold", O_IO_ACK);
    expect_out("io_release", O_IDLE);
    start_cycle(32'hF000_0010, 3'b101);
    step(4); check_out();
    step(8); check_out();
    step(1); check_out();
    AS_n = 1'b1;
    step(3); check_out();
    step(1); check_out();
    step(1);

    // Unmapped: BERR on the edge after DECODE, no select
    expect_out("unmapped_pre", O_IDLE);
    expect_out("unmapped_berr", O_BERR);
    expect_out("unmapped_release_hold", O_BERR);
    expect_out("unmapped_release", O_IDLE);
    start_cycle(32'h9000_0000, 3'b101);
    step(3); check_out();
    step(1); check_out();
    AS_n = 1'b1;
    step(3); check_out();
    step(1); check_out();
    step(1);

    // Interrupt acknowledge: AVEC two edges after leaving DECODE
    expect_out("iack_no_cs", O_IDLE);
    expect_out("iack_not_yet", O_IDLE);
    expect_out("iack_avec", O_AVEC);
    expect_out("iack_release", O_IDLE);
    start_cycle(32'h000F_FFF5, 3'b111);
    step(4); check_out();
    step(1); check_out();
    step(1); check_out();
    AS_n = 1'b1;
    step(4); check_out();
    step(1);

    // Aborted I/O cycle at wait count 2: no ack, no BERR
    expect_out("abort_cnt2", O_IO_CS);
    expect_out("abort_term_hold", O_IO_CS);
    expect_out("abort_release", O_IDLE);
    expect_out("abort_stays_idle", O_IDLE);
    start_cycle(32'hF000_0000, 3'b101);
    step(6); check_out();
    AS_n = 1'b1;
    step(3); check_out();
    step(1); check_out();
    step(10); check_out();

    // DRAM with no acknowledge: BERR exactly TIMEOUT_CYCLES after CS
    expect_out("timeout_cs", O_DRAM_CS);
    expect_out("timeout_pre", O_DRAM_CS);
    expect_out("timeout_berr", O_DRAM_BERR);
    expect_out("timeout_release_hold", O_DRAM_BERR);
    expect_out("timeout_release", O_IDLE);
    start_cycle(32'h0000_2000, 3'b101);
    step(4); check_out();
    step(1023); check_out();
    step(1); check_out();
    AS_n = 1'b1;
    step(3); check_out();
    step(1); check_out();
    step(1);

    // DRAM acknowledge on the same edge as the timeout: ack wins
    expect_out("tie_cs", O_DRAM_CS);
    expect_out("tie_dsack", O_DRAM_ACK);
    expect_out("tie_no_berr", O_DRAM_ACK);
    expect_out("tie_release_hold", O_DRAM_ACK);
    expect_out("tie_release", O_IDLE);
    start_cycle(32'h0000_3000, 3'b101);
    step(4); check_out();
    step(1023);
    DSACK0_DRAM_n = 1'b0; DSACK1_DRAM_n = 1'b0;
    #1; check_out();
    step(1); check_out();
    AS_n = 1'b1;
    step(3); check_out();
    step(1); check_out();
    DSACK0_DRAM_n = 1'b1; DSACK1_DRAM_n = 1'b1;
    step(1);

    // Reset in the middle of a ROM cycle, then the overlay is back
    expect_out("midreset_cs", O_ROM_CS);
    expect_out("midreset_outputs", O_IDLE);
    expect_out("rearm_rom", O_ROM_CS);
    expect_out("rearm_dsack1", O_ROM_ACK);
    expect_out("rearm_release", O_IDLE);
    start_cycle(32'hE000_0100, 3'b110);
    step(4); check_out();
    step(2);
    RST_n = 1'b0;
    AS_n  = 1'b1;
    step(1); check_out();
    RST_n = 1'b1;
    step(2);
    start_cycle(32'h0000_0000, 3'b110);
    step(4); check_out();
    step(5); check_out();
    AS_n = 1'b1;
    step(4); check_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
